// File: rtl/adder_bist_pkg.sv
// Shared definitions for the exhaustive adder BIST controller.
// Contents:
//   bist_state_e   - controller FSM state encoding
//   DefWidth       - default operand width of the adder under test
//   DefLat         - default adder latency in cycles (0 = combinational)
package adder_bist_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } bist_state_e;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefLat   = 0;

endpackage

// File: rtl/adder_bist_ctrl_if.sv
// Bus between the BIST controller and the adder under test.
// Signals:
//   dut_a, dut_b - operands driven to the adder (WIDTH bits each)
//   dut_o        - sum returned by the adder (WIDTH+1 bits)
// Modports:
//   master - controller side (drives operands, samples sum)
//   slave  - adder side (samples operands, drives sum)
interface adder_bist_ctrl_if
  import adder_bist_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
);

  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic [WIDTH:0]   dut_o;

  modport master (
    output dut_a,
    output dut_b,
    input  dut_o
  );

  modport slave (
    input  dut_a,
    input  dut_b,
    output dut_o
  );

endinterface

// File: rtl/adder_bist_pipe.sv
// LAT-deep delay line aligning each applied operand pair (and its expected sum) with the cycle
// in which the adder's result for that pair appears. LAT = 0 is a plain pass-through.
// Ports:
//   clk, rst           - clock, synchronous active-high reset (clears every slot)
//   in_valid/exp/a/b   - slot entering the line this cycle
//   out_valid/exp/a/b  - slot leaving the line, to be compared this cycle
module adder_bist_pipe
  import adder_bist_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned LAT   = DefLat
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH:0]   in_exp,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  output logic [WIDTH:0]   out_exp,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b
);

  localparam int unsigned SlotW = 1 + (WIDTH + 1) + 2 * WIDTH;

  if (LAT == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign out_valid = in_valid;
    assign out_exp   = in_exp;
    assign out_a     = in_a;
    assign out_b     = in_b;
  end else begin : g_delay
    logic [SlotW-1:0] slot_q [LAT];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < LAT; i++) begin
          slot_q[i] <= '0;
        end
      end else begin
        slot_q[0] <= {in_valid, in_exp, in_a, in_b};
        for (int i = 1; i < LAT; i++) begin
          slot_q[i] <= slot_q[i-1];
        end
      end
    end

    assign {out_valid, out_exp, out_a, out_b} = slot_q[LAT-1];
  end

endmodule

// File: rtl/adder_bist_ctrl.sv
// Exhaustive built-in self-test controller for an unsigned WIDTH-bit adder.
// On an accepted start it walks every (a, b) pair once, b as the inner loop, one pair per
// cycle, compares the adder's sum LAT cycles later against a + b, counts mismatches and
// records the first failing pair.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   start            - one-cycle run request, accepted only in idle/done
//   bus (master)     - dut_a/dut_b registered operands out, dut_o sum in
//   busy             - run or drain in progress
//   done             - run finished; held until next accepted start or reset
//   pass             - done with zero mismatches
//   err_cnt          - mismatching pairs in the current/last run
//   first_err_valid  - first_err_* hold a captured mismatch
//   first_err_a/b/o  - operands and observed sum of the first mismatch
module adder_bist_ctrl
  import adder_bist_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned LAT   = DefLat
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  adder_bist_ctrl_if.master  bus,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_cnt,
  output logic               first_err_valid,
  output logic [WIDTH-1:0]   first_err_a,
  output logic [WIDTH-1:0]   first_err_b,
  output logic [WIDTH:0]     first_err_o
);

  localparam int unsigned DrainW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [WIDTH-1:0] OpMax = '1;

  bist_state_e        state_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               busy_q, done_q;
  logic [2*WIDTH:0]   err_cnt_q;
  logic               fe_valid_q;
  logic [WIDTH-1:0]   fe_a_q, fe_b_q;
  logic [WIDTH:0]     fe_o_q;
  logic [DrainW-1:0]  drain_q;

  logic               apply_valid;
  logic [WIDTH:0]     apply_exp;
  logic               chk_valid;
  logic [WIDTH:0]     chk_exp;
  logic [WIDTH-1:0]   chk_a, chk_b;
  logic               mismatch;
  logic               last_pair;
  logic               drain_last;

  // The pair held in a_q/b_q is the one being applied to the adder this cycle.
  assign apply_valid = (state_q == StRun);
  assign apply_exp   = {1'b0, a_q} + {1'b0, b_q};

  adder_bist_pipe #(
    .WIDTH (WIDTH),
    .LAT   (LAT)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (apply_valid),
    .in_exp    (apply_exp),
    .in_a      (a_q),
    .in_b      (b_q),
    .out_valid (chk_valid),
    .out_exp   (chk_exp),
    .out_a     (chk_a),
    .out_b     (chk_b)
  );

  assign mismatch   = chk_valid && (bus.dut_o != chk_exp);
  assign last_pair  = (a_q == OpMax) && (b_q == OpMax);
  // Unreachable when LAT = 0; the cast only keeps the expression well-formed.
  assign drain_last = (drain_q == DrainW'(LAT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_cnt_q  <= '0;
      fe_valid_q <= 1'b0;
      fe_a_q     <= '0;
      fe_b_q     <= '0;
      fe_o_q     <= '0;
      drain_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q    <= StRun;
            a_q        <= '0;
            b_q        <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_cnt_q  <= '0;
            fe_valid_q <= 1'b0;
            fe_a_q     <= '0;
            fe_b_q     <= '0;
            fe_o_q     <= '0;
          end
        end
        StRun: begin
          if (last_pair) begin
            // Operands stay on the last pair through drain and done.
            if (LAT == 0) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StDrain;
              drain_q <= '0;
            end
          end else begin
            b_q <= b_q + 1'b1;
            if (b_q == OpMax) begin
              a_q <= a_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (drain_last) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase

      // The delay line is empty whenever a start can be accepted, so this never collides
      // with the clear above.
      if (mismatch) begin
        err_cnt_q <= err_cnt_q + 1'b1;
        if (!fe_valid_q) begin
          fe_valid_q <= 1'b1;
          fe_a_q     <= chk_a;
          fe_b_q     <= chk_b;
          fe_o_q     <= bus.dut_o;
        end
      end
    end
  end

  assign bus.dut_a       = a_q;
  assign bus.dut_b       = b_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = done_q && (err_cnt_q == '0);
  assign err_cnt         = err_cnt_q;
  assign first_err_valid = fe_valid_q;
  assign first_err_a     = fe_a_q;
  assign first_err_b     = fe_b_q;
  assign first_err_o     = fe_o_q;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Directed bench for adder_bist_ctrl at WIDTH = 4 (256 pairs per run).
// Instance 0: LAT = 0 against a combinational adder with selectable faults.
// Instances 1/2: LAT = 2 and LAT = 1 against the same two-stage registered adder.
module tb_adder_bist_ctrl;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start0;
  logic       start12;
  logic [1:0] fault;  // 0 clean, 1 returns 0 for (3,5), 2 sum bit W stuck at 0

  int checks = 0;
  int errors = 0;

  adder_bist_ctrl_if #(.WIDTH(W)) bus0 ();
  adder_bist_ctrl_if #(.WIDTH(W)) bus1 ();
  adder_bist_ctrl_if #(.WIDTH(W)) bus2 ();

  logic           busy0, done0, pass0, fev0;
  logic [2*W:0]   err0;
  logic [W-1:0]   fea0, feb0;
  logic [W:0]     feo0;
  logic           busy1, done1, pass1, fev1;
  logic [2*W:0]   err1;
  logic [W-1:0]   fea1, feb1;
  logic [W:0]     feo1;
  logic           busy2, done2, pass2, fev2;
  logic [2*W:0]   err2;
  logic [W-1:0]   fea2, feb2;
  logic [W:0]     feo2;

  // Adder models
  always_comb begin
    logic [W:0] sum;
    sum = {1'b0, bus0.dut_a} + {1'b0, bus0.dut_b};
    case (fault)
      2'd1:    bus0.dut_o = (bus0.dut_a == 4'd3 && bus0.dut_b == 4'd5) ? '0 : sum;
      2'd2:    bus0.dut_o = {1'b0, sum[W-1:0]};
      default: bus0.dut_o = sum;
    endcase
  end

  logic [W:0] r1_s1, r1_s2, r2_s1, r2_s2;
  always @(posedge clk) begin
    r1_s1 <= {1'b0, bus1.dut_a} + {1'b0, bus1.dut_b};
    r1_s2 <= r1_s1;
    r2_s1 <= {1'b0, bus2.dut_a} + {1'b0, bus2.dut_b};
    r2_s2 <= r2_s1;
  end
  assign bus1.dut_o = r1_s2;
  assign bus2.dut_o = r2_s2;

  adder_bist_ctrl #(.WIDTH(W), .LAT(0)) u_dut0 (
    .clk (clk), .rst (rst), .start (start0), .bus (bus0),
    .busy (busy0), .done (done0), .pass (pass0), .err_cnt (err0),
    .first_err_valid (fev0), .first_err_a (fea0), .first_err_b (feb0), .first_err_o (feo0)
  );

  adder_bist_ctrl #(.WIDTH(W), .LAT(2)) u_dut1 (
    .clk (clk), .rst (rst), .start (start12), .bus (bus1),
    .busy (busy1), .done (done1), .pass (pass1), .err_cnt (err1),
    .first_err_valid (fev1), .first_err_a (fea1), .first_err_b (feb1), .first_err_o (feo1)
  );

  adder_bist_ctrl #(.WIDTH(W), .LAT(1)) u_dut2 (
    .clk (clk), .rst (rst), .start (start12), .bus (bus2),
    .busy (busy2), .done (done2), .pass (pass2), .err_cnt (err2),
    .first_err_valid (fev2), .first_err_a (fea2), .first_err_b (feb2), .first_err_o (feo2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue start at a negedge; returns at the next negedge (first RUN cycle if accepted).
  task automatic pulse0();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  // Counts busy cycles of instance 0 from the current negedge until busy drops.
  task automatic count0(output int cyc);
    cyc = 0;
    while (busy0 && cyc < 2000) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    int c0, c1, c2;
    rst     = 1'b1;
    start0  = 1'b0;
    start12 = 1'b0;
    fault   = 2'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    check("rst_err", err0, 0);
    check("rst_fev", fev0, 0);
    check("rst_a", bus0.dut_a, 0);

    // Reset wins over a simultaneous start
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("rst_prio_busy", busy0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Clean exhaustive run
    pulse0();
    check("clean_busy0", busy0, 1);
    check("clean_a0", bus0.dut_a, 0);
    check("clean_b0", bus0.dut_b, 0);
    count0(c0);
    check("clean_cycles", c0, 256);
    check("clean_done", done0, 1);
    check("clean_pass", pass0, 1);
    check("clean_err", err0, 0);
    check("clean_fev", fev0, 0);
    check("clean_hold_a", bus0.dut_a, 15);
    check("clean_hold_b", bus0.dut_b, 15);
    repeat (3) @(negedge clk);
    check("clean_done_held", done0, 1);

    // Single faulty pair (3,5)
    fault = 2'd1;
    pulse0();
    count0(c0);
    check("pt_cycles", c0, 256);
    check("pt_err", err0, 1);
    check("pt_fev", fev0, 1);
    check("pt_fea", fea0, 3);
    check("pt_feb", feb0, 5);
    check("pt_feo", feo0, 0);
    check("pt_pass", pass0, 0);
    check("pt_done", done0, 1);

    // Carry-out stuck at 0: pairs with a+b >= 16 fail (256 - 136 = 120); first is (1,15)
    fault = 2'd2;
    pulse0();
    count0(c0);
    check("sa_err", err0, 120);
    check("sa_fea", fea0, 1);
    check("sa_feb", feb0, 15);
    check("sa_feo", feo0, 0);
    check("sa_pass", pass0, 0);

    // Start during RUN is ignored; start in DONE restarts cleanly
    fault = 2'd1;
    pulse0();
    c0 = 0;
    while (busy0 && c0 < 2000) begin
      start0 = (c0 == 10);
      c0++;
      @(negedge clk);
    end
    start0 = 1'b0;
    check("ign_cycles", c0, 256);
    check("ign_err", err0, 1);
    pulse0();
    check("rs_done", done0, 0);
    check("rs_busy", busy0, 1);
    check("rs_err", err0, 0);
    check("rs_fev", fev0, 0);
    check("rs_a", bus0.dut_a, 0);
    check("rs_b", bus0.dut_b, 0);
    count0(c0);
    check("rs_cycles", c0, 256);
    check("rs_err_end", err0, 1);

    // Reset in the middle of a run (pair 53 already failed by cycle 100)
    pulse0();
    repeat (100) @(negedge clk);
    check("mid_err_pre", err0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_busy", busy0, 0);
    check("mid_done", done0, 0);
    check("mid_pass", pass0, 0);
    check("mid_err", err0, 0);
    check("mid_fev", fev0, 0);
    check("mid_fea", fea0, 0);
    check("mid_feb", feb0, 0);
    check("mid_feo", feo0, 0);
    check("mid_a", bus0.dut_a, 0);
    check("mid_b", bus0.dut_b, 0);
    fault = 2'd0;
    @(negedge clk);
    pulse0();
    count0(c0);
    check("mid_rerun_cycles", c0, 256);
    check("mid_rerun_pass", pass0, 1);

    // Latency alignment: LAT=2 matches the two-stage adder; LAT=1 is off by one, so every
    // pair after (0,0) is compared against its predecessor's sum (which always differs).
    start12 = 1'b1;
    @(negedge clk);
    start12 = 1'b0;
    c1 = 0;
    c2 = 0;
    while ((busy1 || busy2) && c1 < 2000) begin
      if (busy1) c1++;
      if (busy2) c2++;
      @(negedge clk);
    end
    check("l2_cycles", c1, 258);
    check("l2_pass", pass1, 1);
    check("l2_err", err1, 0);
    check("l1_cycles", c2, 257);
    check("l1_err", err2, 255);
    check("l1_pass", pass2, 0);
    check("l1_done", done2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
